// File: rtl/uart_pkg.sv
// Shared UART receiver definitions: FSM states, parameter bounds and parity helper.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_e;

  localparam int DATA_BITS_MIN  = 5;
  localparam int DATA_BITS_MAX  = 9;
  localparam int OVERSAMPLE_MIN = 8;
  localparam int OVERSAMPLE_MAX = 32;

  // Callers zero-extend narrower words; the extra zeros do not change the XOR.
  function automatic logic par_calc(input logic [DATA_BITS_MAX-1:0] data,
                                    input logic                     odd);
    return (^data) ^ odd;
  endfunction

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchroniser for an asynchronous single-bit input, with a selectable reset value.
module uart_sync2 #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta_q;
  logic sync_q;

  // NOTE: non-blocking assignments make both flops sample together; blocking would collapse the chain into one flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/uart_rx_param.sv
// Parametrised oversampling UART receiver with parity/stop checks, a valid/ready
// holding register and one-clk error pulses.
module uart_rx_param
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 tick,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] m_data,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 overrun_err,
  output logic                 busy
);

  localparam int CNT_W = $clog2(OVERSAMPLE);
  localparam int IDX_W = $clog2(DATA_BITS + 1);

  localparam logic [CNT_W-1:0] CNT_MID   = CNT_W'(OVERSAMPLE / 2 - 1);
  localparam logic [CNT_W-1:0] CNT_END   = CNT_W'(OVERSAMPLE - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DATA_BITS - 1);
  localparam logic [IDX_W-1:0] STOP_LAST = IDX_W'(STOP_BITS - 1);

  if (DATA_BITS < DATA_BITS_MIN || DATA_BITS > DATA_BITS_MAX ||
      OVERSAMPLE < OVERSAMPLE_MIN || OVERSAMPLE > OVERSAMPLE_MAX ||
      (OVERSAMPLE % 2) != 0 || STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_params
    $error("uart_rx_param: illegal parameter combination");
  end

  logic rx_s;

  uart_sync2 #(.RST_VAL(1'b1)) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (rx),
    .q     (rx_s)
  );

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 p_bad_q, p_bad_d;
  logic                 stop_bad_q, stop_bad_d;
  logic                 armed_q, armed_d;
  logic [DATA_BITS-1:0] m_data_q, m_data_d;
  logic                 m_valid_q, m_valid_d;
  logic                 frame_err_q, frame_err_d;
  logic                 parity_err_q, parity_err_d;
  logic                 overrun_err_q, overrun_err_d;
  logic                 busy_q, busy_d;

  logic                     frame_done;
  logic                     stop_bad_now;
  logic [DATA_BITS_MAX-1:0] par_word;

  // NOTE: every signal assigned here gets a default first, so no path leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    idx_d         = idx_q;
    shift_d       = shift_q;
    p_bad_d       = p_bad_q;
    stop_bad_d    = stop_bad_q;
    armed_d       = armed_q;
    m_data_d      = m_data_q;
    m_valid_d     = m_valid_q;
    frame_err_d   = 1'b0;
    parity_err_d  = 1'b0;
    overrun_err_d = 1'b0;
    frame_done    = 1'b0;
    stop_bad_now  = stop_bad_q;
    par_word      = '0;
    par_word[DATA_BITS-1:0] = shift_q;

    if (m_valid_q && m_ready) begin
      m_valid_d = 1'b0;
    end

    if (tick) begin
      unique case (state_q)
        IDLE: begin
          // After a break the line must be seen high again before a new start is accepted.
          if (rx_s) begin
            armed_d = 1'b1;
          end else if (armed_q) begin
            cnt_d   = '0;
            state_d = START;
          end
        end

        START: begin
          if (cnt_q == CNT_MID) begin
            cnt_d      = '0;
            idx_d      = '0;
            p_bad_d    = 1'b0;
            stop_bad_d = 1'b0;
            state_d    = rx_s ? IDLE : DATA;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end

        DATA: begin
          if (cnt_q == CNT_END) begin
            cnt_d   = '0;
            // LSB arrives first, so after DATA_BITS right-shifts it sits at bit 0.
            shift_d = {rx_s, shift_q[DATA_BITS-1:1]};
            if (idx_q == IDX_LAST) begin
              idx_d   = '0;
              state_d = (PARITY_EN != 0) ? PARITY : STOP;
            end else begin
              idx_d = idx_q + IDX_W'(1);
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end

        PARITY: begin
          if (cnt_q == CNT_END) begin
            cnt_d   = '0;
            p_bad_d = (rx_s != par_calc(par_word, 1'(PARITY_ODD)));
            state_d = STOP;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end

        STOP: begin
          if (cnt_q == CNT_END) begin
            cnt_d        = '0;
            stop_bad_now = stop_bad_q | ~rx_s;
            stop_bad_d   = stop_bad_now;
            if (idx_q == STOP_LAST) begin
              idx_d      = '0;
              armed_d    = rx_s;
              frame_done = 1'b1;
              state_d    = IDLE;
            end else begin
              idx_d = idx_q + IDX_W'(1);
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end

        default: state_d = IDLE;
      endcase
    end

    // Framing errors mask parity; a good word only loads if the holding slot frees this clk.
    if (frame_done) begin
      if (stop_bad_now) begin
        frame_err_d = 1'b1;
      end else if (p_bad_q) begin
        parity_err_d = 1'b1;
      end else if (!m_valid_q || m_ready) begin
        m_data_d  = shift_q;
        m_valid_d = 1'b1;
      end else begin
        overrun_err_d = 1'b1;
      end
    end

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      idx_q         <= '0;
      shift_q       <= '0;
      p_bad_q       <= 1'b0;
      stop_bad_q    <= 1'b0;
      armed_q       <= 1'b1;
      m_data_q      <= '0;
      m_valid_q     <= 1'b0;
      frame_err_q   <= 1'b0;
      parity_err_q  <= 1'b0;
      overrun_err_q <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      idx_q         <= idx_d;
      shift_q       <= shift_d;
      p_bad_q       <= p_bad_d;
      stop_bad_q    <= stop_bad_d;
      armed_q       <= armed_d;
      m_data_q      <= m_data_d;
      m_valid_q     <= m_valid_d;
      frame_err_q   <= frame_err_d;
      parity_err_q  <= parity_err_d;
      overrun_err_q <= overrun_err_d;
      busy_q        <= busy_d;
    end
  end

  assign m_data      = m_data_q;
  assign m_valid     = m_valid_q;
  assign frame_err   = frame_err_q;
  assign parity_err  = parity_err_q;
  assign overrun_err = overrun_err_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_uart_rx_param.sv
// Scoreboard bench for uart_rx_param: an 8N1 instance and an 8E2 instance driven with
// directed and random frames, outcomes predicted from frame contents alone.
`timescale 1ns/1ps
module tb_uart_rx_param;

  localparam int OS  = 16;
  localparam int DW  = 8;
  localparam bit ODD = 1'b0;

  typedef enum int {EV_NONE, EV_FRAME, EV_PARITY, EV_OVERRUN} ev_e;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          tick;
  logic [1:0]    rx;
  logic [1:0]    m_ready;
  logic [1:0]    m_valid;
  logic [1:0]    frame_err;
  logic [1:0]    parity_err;
  logic [1:0]    overrun_err;
  logic [1:0]    busy;
  logic [DW-1:0] m_data [2];

  int tick_div = 1;
  int n_checks = 0;
  int n_pass   = 0;

  int  data_q0[$];
  int  data_q1[$];
  ev_e err_q0[$];
  ev_e err_q1[$];
  bit  full [2];

  uart_rx_param u_dut_n1 (
    .clk         (clk),
    .rst_n       (rst_n),
    .tick        (tick),
    .rx          (rx[0]),
    .m_data      (m_data[0]),
    .m_valid     (m_valid[0]),
    .m_ready     (m_ready[0]),
    .frame_err   (frame_err[0]),
    .parity_err  (parity_err[0]),
    .overrun_err (overrun_err[0]),
    .busy        (busy[0])
  );

  uart_rx_param #(
    .DATA_BITS  (DW),
    .OVERSAMPLE (OS),
    .PARITY_EN  (1),
    .PARITY_ODD (0),
    .STOP_BITS  (2)
  ) u_dut_e2 (
    .clk         (clk),
    .rst_n       (rst_n),
    .tick        (tick),
    .rx          (rx[1]),
    .m_data      (m_data[1]),
    .m_valid     (m_valid[1]),
    .m_ready     (m_ready[1]),
    .frame_err   (frame_err[1]),
    .parity_err  (parity_err[1]),
    .overrun_err (overrun_err[1]),
    .busy        (busy[1])
  );

  always #5 clk = ~clk;

  initial begin : tick_gen
    int c;
    c    = 0;
    tick = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      tick = (c == 0);
      c    = (c + 1 >= tick_div) ? 0 : c + 1;
    end
  end

  initial begin : watchdog
    #950000;
    $display("FAIL watchdog: simulation did not finish within the cycle budget");
    $fatal(1);
  end

  function automatic bit pen_of(input int d);
    return d == 1;
  endfunction

  function automatic bit stop2_of(input int d);
    return d == 1;
  endfunction

  function automatic logic good_par(input logic [DW-1:0] data);
    return (^data) ^ ODD;
  endfunction

  task automatic check(input string name, input int d, input longint got, input longint exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s dut%0d: got 0x%0h expected 0x%0h", name, d, got, exp);
  endtask

  function automatic void push_data(input int d, input int v);
    if (d == 0) data_q0.push_back(v);
    else        data_q1.push_back(v);
  endfunction

  function automatic void push_err(input int d, input ev_e e);
    if (d == 0) err_q0.push_back(e);
    else        err_q1.push_back(e);
  endfunction

  function automatic int pop_data(input int d);
    if (d == 0) return (data_q0.size() != 0) ? data_q0.pop_front() : -1;
    return (data_q1.size() != 0) ? data_q1.pop_front() : -1;
  endfunction

  function automatic ev_e pop_err(input int d);
    if (d == 0) return (err_q0.size() != 0) ? err_q0.pop_front() : EV_NONE;
    return (err_q1.size() != 0) ? err_q1.pop_front() : EV_NONE;
  endfunction

  function automatic int pending();
    return data_q0.size() + data_q1.size() + err_q0.size() + err_q1.size();
  endfunction

  // Reference model: outcome of one frame from its line contents and the consumer state.
  task automatic expect_frame(input int d, input logic [DW-1:0] data, input logic pbit,
                              input logic s0, input logic s1);
    bit stop_ok;
    bit par_ok;
    stop_ok = s0 && (!stop2_of(d) || s1);
    par_ok  = !pen_of(d) || (pbit == good_par(data));
    if (!stop_ok)                   push_err(d, EV_FRAME);
    else if (!par_ok)               push_err(d, EV_PARITY);
    else if (!m_ready[d] && full[d]) push_err(d, EV_OVERRUN);
    else begin
      push_data(d, int'(data));
      if (!m_ready[d]) full[d] = 1'b1;
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drive_bit(input int d, input logic v);
    rx[d] = v;
    step(OS * tick_div);
  endtask

  task automatic idle_bits(input int n);
    step(n * OS * tick_div);
  endtask

  task automatic send_frame(input int d, input logic [DW-1:0] data, input logic pbit,
                            input logic s0, input logic s1);
    expect_frame(d, data, pbit, s0, s1);
    drive_bit(d, 1'b0);
    for (int i = 0; i < DW; i++) drive_bit(d, data[i]);
    if (pen_of(d)) drive_bit(d, pbit);
    drive_bit(d, s0);
    if (stop2_of(d)) drive_bit(d, s1);
    rx[d] = 1'b1;
  endtask

  task automatic send_good(input int d, input logic [DW-1:0] data);
    send_frame(d, data, good_par(data), 1'b1, 1'b1);
  endtask

  task automatic monitor_dut(input int d);
    if (frame_err[d])   check("error_kind_frame",   d, int'(EV_FRAME),   int'(pop_err(d)));
    if (parity_err[d])  check("error_kind_parity",  d, int'(EV_PARITY),  int'(pop_err(d)));
    if (overrun_err[d]) check("error_kind_overrun", d, int'(EV_OVERRUN), int'(pop_err(d)));
    if (m_valid[d] && m_ready[d]) check("word", d, m_data[d], pop_data(d));
  endtask

  task automatic check_reset_outputs();
    for (int d = 0; d < 2; d++) begin
      check("rst_m_data",      d, m_data[d],      0);
      check("rst_m_valid",     d, m_valid[d],     0);
      check("rst_frame_err",   d, frame_err[d],   0);
      check("rst_parity_err",  d, parity_err[d],  0);
      check("rst_overrun_err", d, overrun_err[d], 0);
      check("rst_busy",        d, busy[d],        0);
    end
  endtask

  initial begin : main
    logic [DW-1:0] data;
    logic          pbit, s0, s1, last_stop;
    int            gap;

    rx       = 2'b11;
    m_ready  = 2'b11;
    rst_n    = 1'b0;
    full     = '{1'b0, 1'b0};
    step(3);
    check_reset_outputs();
    rst_n = 1'b1;
    step(5);

    fork
      forever begin
        @(negedge clk);
        if (rst_n) begin
          for (int d = 0; d < 2; d++) monitor_dut(d);
        end
      end
    join_none

    // Plain 8N1 word with an always-ready consumer.
    send_good(0, 8'hA5);
    idle_bits(2);

    // Even parity: wrong bit first, then the correct one.
    send_frame(1, 8'h03, 1'b1, 1'b1, 1'b1);
    idle_bits(2);
    send_good(1, 8'h03);
    idle_bits(2);

    // Stalled consumer: second back-to-back word is dropped.
    m_ready[0] = 1'b0;
    send_good(0, 8'h11);
    send_good(0, 8'h22);
    idle_bits(2);
    check("held_valid", 0, m_valid[0], 1);
    check("held_word",  0, m_data[0],  8'h11);
    m_ready[0] = 1'b1;
    full[0]    = 1'b0;
    idle_bits(1);

    // Bad stop bit on the single-stop unit and bad second stop on the two-stop unit.
    send_frame(0, 8'h55, 1'b0, 1'b0, 1'b1);
    idle_bits(2);
    send_frame(1, 8'h55, good_par(8'h55), 1'b1, 1'b0);
    idle_bits(2);

    // Short low glitch must not start a frame.
    rx[0] = 1'b0;
    step(4 * tick_div);
    rx[0] = 1'b1;
    idle_bits(2);
    check("busy_after_glitch", 0, busy[0], 0);
    send_good(0, 8'h7E);
    idle_bits(2);

    // Break: a single frame error, then silence until the line returns high.
    expect_frame(0, 8'h00, 1'b0, 1'b0, 1'b0);
    rx[0] = 1'b0;
    idle_bits(15);
    rx[0] = 1'b1;
    idle_bits(2);

    // Reset in the middle of a data phase.
    drive_bit(0, 1'b0);
    drive_bit(0, 1'b0);
    drive_bit(0, 1'b0);
    drive_bit(0, 1'b1);
    check("busy_mid_frame", 0, busy[0], 1);
    rst_n = 1'b0;
    rx[0] = 1'b1;
    step(2);
    check_reset_outputs();
    full  = '{1'b0, 1'b0};
    rst_n = 1'b1;
    idle_bits(2);
    send_good(0, 8'hC3);
    idle_bits(2);

    // Random frames with random errors, consumer stalls and tick spacing.
    for (int d = 0; d < 2; d++) begin
      for (int n = 0; n < 20; n++) begin
        if ($urandom_range(0, 3) == 0) begin
          m_ready[d] = 1'($urandom_range(0, 1));
          if (m_ready[d]) full[d] = 1'b0;
          step(2);
        end
        if ($urandom_range(0, 3) == 0) tick_div = $urandom_range(1, 3);
        data      = DW'($urandom);
        pbit      = ($urandom_range(0, 3) == 0) ? ~good_par(data) : good_par(data);
        s0        = ($urandom_range(0, 9) != 0);
        s1        = ($urandom_range(0, 9) != 0);
        last_stop = stop2_of(d) ? s1 : s0;
        send_frame(d, data, pbit, s0, s1);
        gap = last_stop ? $urandom_range(0, 2) : $urandom_range(1, 2);
        idle_bits(gap);
      end
      m_ready[d] = 1'b1;
      full[d]    = 1'b0;
      idle_bits(1);
    end

    for (int i = 0; i < 5000 && pending() != 0; i++) step(1);
    step(10);
    check("words_outstanding",  0, data_q0.size(), 0);
    check("words_outstanding",  1, data_q1.size(), 0);
    check("errors_outstanding", 0, err_q0.size(),  0);
    check("errors_outstanding", 1, err_q1.size(),  0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/uart_rx_param.md
Name: uart_rx_param

Overview:
Parametrised next-generation UART receiver. Supports configurable data width, optional even/odd parity, and one or two stop bits. Has a synchronised serial input, a valid/ready output holding register, and per-error pulse flags. Sits between the pad-side rx line and any byte consumer (FIFO, CSR block), driven by the shared baud-tick generator at OVERSAMPLE x baud.

Parameters:
DATA_BITS, 8, data bits per frame; legal 5..9; LSB first on the line.
OVERSAMPLE, 16, ticks per bit; even, 8..32.
PARITY_EN, 0, 1 = one parity bit follows the data bits.
PARITY_ODD, 0, used only when PARITY_EN=1; 0 = even parity, 1 = odd parity.
STOP_BITS, 1, 1 or 2.

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
tick  in  1  one-clk oversample strobe
rx  in  1  asynchronous serial input, idle high
m_data  out  DATA_BITS  received word
m_valid  out  1  m_data holds an unconsumed word
m_ready  in  1  consumer accepts m_data this clk
frame_err  out  1  one-clk pulse: a stop bit was sampled 0
parity_err  out  1  one-clk pulse: parity mismatch
overrun_err  out  1  one-clk pulse: good word dropped because holding register full
busy  out  1  high whenever the FSM is not in IDLE

Behaviour:
- Reset (rst_n low, async):
  - FSM goes to IDLE; all counters cleared.
  - m_data=0, m_valid=0, all error pulses 0, busy=0.
  - Both synchroniser flops reset to 1.
- rx passes through a 2-flop synchroniser. rx_s is the second flop; all sampling uses rx_s.
- The FSM advances only on clk edges where tick=1. The output handshake and error pulses are evaluated every clk.
- IDLE: on tick with rx_s=0, clear the sample counter and go to START.
- START: count ticks. At count OVERSAMPLE/2-1 (mid-bit):
  - rx_s=0: clear the counter and bit index, go to DATA.
  - rx_s=1: glitch; return to IDLE with no error flag.
- DATA: at count OVERSAMPLE-1, shift rx_s into shift[bit_idx] and clear the counter.
  - After bit DATA_BITS-1: go to PARITY if PARITY_EN, else STOP.
- PARITY: at count OVERSAMPLE-1, latch rx_s as p_rx.
  - Required value is XOR(data) ^ PARITY_ODD.
  - p_bad = (p_rx != required value).
- STOP: at count OVERSAMPLE-1, sample the stop bit.
  - With STOP_BITS=2, a second full bit period is also sampled; every stop sample must be 1.
  - After the final stop sample, go to IDLE. A new start edge may therefore be detected in the second half of the stop bit, so back-to-back frames are supported.
- Frame completion happens on the clk of the final stop sample. Priority order:
  1. Any stop sample 0: pulse frame_err; discard the word; no parity_err reported.
  2. Else if p_bad: pulse parity_err; discard the word.
  3. Else (good word):
     - If m_valid=0, or m_valid=1 and m_ready=1 in the same clk: load m_data and set m_valid=1.
     - Otherwise keep the old m_data, drop the new word, and pulse overrun_err.
- Handshake:
  - m_valid falls on the clk after m_valid & m_ready, unless a good word loads in the same clk. In that case m_valid stays 1 and m_data updates.
  - m_data is stable while m_valid=1 and m_ready=0.
- Error pulses are exactly one clk wide, independent of tick spacing.
- A break (line held low) produces a frame_err for each frame; the FSM then stays in IDLE until rx_s returns to 1 and falls again. The IDLE start-detect is level-based, but STOP requires a high sample before re-arming.
- A reset mid-frame aborts the frame silently; no flags are raised after release.
- Counter width is $clog2(OVERSAMPLE); bit index width is $clog2(DATA_BITS+1).

Decomposition:
- Shared package uart_pkg holds:
  - state enum (IDLE, START, DATA, PARITY, STOP);
  - localparams for legal DATA_BITS/OVERSAMPLE bounds;
  - the parity function par_calc(data, odd).
- One sub-module, uart_sync2: the 2-flop synchroniser with reset value 1, reused by future receivers.
- FSM, shift register, checks and the output register live in uart_rx_param.

Test Plan:
1. Default params, tick every clk, m_ready=1, send 0xA5 (8N1) -> m_valid for exactly one clk with m_data=0xA5; no error pulses.
2. PARITY_EN=1, PARITY_ODD=0, send 0x03 with parity bit 1 (wrong) -> parity_err pulse, m_valid stays 0. Resend with parity 0 -> m_data=0x03, m_valid=1.
3. m_ready=0, send 0x11 then 0x22 back-to-back -> m_data holds 0x11, overrun_err pulses once at 0x22's stop sample. Raise m_ready -> 0x11 consumed, m_valid falls.
4. Send 0x55 with stop bit 0; STOP_BITS=2 variant with only the second stop 0 -> frame_err each time, no m_valid, no parity_err.
5. rx low pulse of 4 ticks (OVERSAMPLE=16), then idle -> returns to IDLE, busy drops, no flags. A following valid 0x7E is received correctly.
6. Assert rst_n low mid-DATA of frame 0x3C, release, send 0xC3 -> only 0xC3 delivered; all outputs 0 during reset.
